// File: rtl/palindrome_word_framer.sv
// Serial-to-word framer feeding an external combinational palindrome detector;
// returns {word, verdict} on a valid/ready handshake and keeps saturating counts.
module palindrome_word_framer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] pal_d,
  input  logic             pal_x,
  output logic [WIDTH-1:0] res_word,
  output logic             res_pal,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] pal_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {COLLECT, EVAL, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-1:0] pal_d_q, pal_d_d;
  logic [WIDTH-1:0] res_word_q, res_word_d;
  logic             res_pal_q, res_pal_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] pal_cnt_q, pal_cnt_d;
  logic             xfer;
  logic             hs;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bcnt_d     = bcnt_q;
    pal_d_d    = pal_d_q;
    res_word_d = res_word_q;
    res_pal_d  = res_pal_q;
    word_cnt_d = word_cnt_q;
    pal_cnt_d  = pal_cnt_q;
    bit_ready  = (state_q == COLLECT);
    res_valid  = (state_q == HOLD);
    xfer       = bit_valid & bit_ready;
    hs         = res_valid & res_ready;

    case (state_q)
      COLLECT: begin
        if (xfer) begin
          sh_d = {sh_q[WIDTH-2:0], bit_in};
          if (bcnt_q == LAST) begin
            pal_d_d = {sh_q[WIDTH-2:0], bit_in};
            bcnt_d  = '0;
            state_d = EVAL;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      EVAL: begin
        res_word_d = pal_d_q;
        res_pal_d  = pal_x;
        state_d    = HOLD;
      end
      HOLD: begin
        if (hs) begin
          if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
          if (res_pal_q && (pal_cnt_q != '1)) pal_cnt_d = pal_cnt_q + 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Abort wins over framing, but a handshake already in flight still counts.
    if (flush) begin
      state_d    = COLLECT;
      sh_d       = '0;
      bcnt_d     = '0;
      pal_d_d    = pal_d_q;
      res_word_d = res_word_q;
      res_pal_d  = res_pal_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      sh_q       <= '0;
      bcnt_q     <= '0;
      pal_d_q    <= '0;
      res_word_q <= '0;
      res_pal_q  <= 1'b0;
      word_cnt_q <= '0;
      pal_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bcnt_q     <= bcnt_d;
      pal_d_q    <= pal_d_d;
      res_word_q <= res_word_d;
      res_pal_q  <= res_pal_d;
      word_cnt_q <= word_cnt_d;
      pal_cnt_q  <= pal_cnt_d;
    end
  end

  assign pal_d    = pal_d_q;
  assign res_word = res_word_q;
  assign res_pal  = res_pal_q;
  assign word_cnt = word_cnt_q;
  assign pal_cnt  = pal_cnt_q;

endmodule
